// File: rtl/awg_seq_loader.sv
// rtl/awg_seq_loader.sv - AWG sequencer-index serial loader (two frames, sclk/load strobes)
// Optional upper-index cache enabled by defining AWG_LOADER_UPPER_CACHE_EN.
module awg_seq_loader #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [18:0] seq_index,
    output logic        busy,
    output logic        done,
    output logic [15:0] mux_data,
    output logic [3:0]  mux_select,
    input  logic        mux_bit,
    output logic        awg_sdata,
    output logic        awg_sclk,
    output logic        awg_load
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        GAP
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  phase, phase_n;
    logic        frame_b, frame_b_n;
    logic [18:0] idx, idx_n;
    logic        busy_n, done_n, sclk_n, load_n;
    logic [15:0] data_n;
    logic [3:0]  select_n;
    logic        phase_last;
    logic [3:0]  last_bit;

`ifdef AWG_LOADER_UPPER_CACHE_EN
    logic [5:0]  cache_upper, cache_upper_n;
    logic        cache_valid, cache_valid_n;
`endif

    // Frame bit k sits at word bit k+1 because select k routes data[k+1].
    function automatic logic [15:0] frame_a_word(input logic [18:0] v);
        logic [15:0] w;
        w    = '0;
        w[1] = 1'b1;
        for (int i = 0; i < 6; i++) w[2+i] = v[18-i];
        return w;
    endfunction

    function automatic logic [15:0] frame_b_word(input logic [18:0] v);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 13; i++) w[2+i] = v[12-i];
        return w;
    endfunction

    assign phase_last = (phase == PHASE_LAST);
    assign last_bit   = frame_b ? 4'd13 : 4'd6;

    always_comb begin
        state_n   = state;
        phase_n   = phase + 8'd1;
        frame_b_n = frame_b;
        idx_n     = idx;
        busy_n    = busy;
        done_n    = 1'b0;
        data_n    = mux_data;
        select_n  = mux_select;
`ifdef AWG_LOADER_UPPER_CACHE_EN
        cache_upper_n = cache_upper;
        cache_valid_n = cache_valid;
`endif
        case (state)
            IDLE: begin
                phase_n = 8'd0;
                if (start) begin
                    idx_n     = seq_index;
                    busy_n    = 1'b1;
                    select_n  = 4'd0;
                    state_n   = SHIFT_LO;
                    data_n    = frame_a_word(seq_index);
                    frame_b_n = 1'b0;
`ifdef AWG_LOADER_UPPER_CACHE_EN
                    // AWG already holds this upper index: go straight to frame B.
                    if (cache_valid && (seq_index[18:13] == cache_upper)) begin
                        data_n    = frame_b_word(seq_index);
                        frame_b_n = 1'b1;
                    end
`endif
                end
            end
            SHIFT_LO: begin
                if (phase_last) begin
                    phase_n = 8'd0;
                    state_n = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    phase_n = 8'd0;
                    if (mux_select == last_bit) begin
                        state_n = LOAD;
                    end else begin
                        select_n = mux_select + 4'd1;
                        state_n  = SHIFT_LO;
                    end
                end
            end
            LOAD: begin
                if (phase_last) begin
                    phase_n = 8'd0;
                    if (frame_b) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = GAP;
`ifdef AWG_LOADER_UPPER_CACHE_EN
                        cache_upper_n = idx[18:13];
                        cache_valid_n = 1'b1;
`endif
                    end
                end
            end
            GAP: begin
                if (phase_last) begin
                    phase_n   = 8'd0;
                    data_n    = frame_b_word(idx);
                    select_n  = 4'd0;
                    frame_b_n = 1'b1;
                    state_n   = SHIFT_LO;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = 8'd0;
            end
        endcase
        // Strobes are registered from the next state so they align with it.
        sclk_n = (state_n == SHIFT_HI);
        load_n = (state_n == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 8'd0;
            frame_b    <= 1'b0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mux_data   <= 16'h0000;
            mux_select <= 4'd0;
            awg_sclk   <= 1'b0;
            awg_load   <= 1'b0;
            awg_sdata  <= 1'b0;
`ifdef AWG_LOADER_UPPER_CACHE_EN
            cache_upper <= '0;
            cache_valid <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            frame_b    <= frame_b_n;
            idx        <= idx_n;
            busy       <= busy_n;
            done       <= done_n;
            mux_data   <= data_n;
            mux_select <= select_n;
            awg_sclk   <= sclk_n;
            awg_load   <= load_n;
            awg_sdata  <= mux_bit;
`ifdef AWG_LOADER_UPPER_CACHE_EN
            cache_upper <= cache_upper_n;
            cache_valid <= cache_valid_n;
`endif
        end
    end

endmodule

// File: tb/tb_awg_seq_loader.sv
// tb/tb_awg_seq_loader.sv - directed self-checking bench for awg_seq_loader (CLK_DIV=4)
// Also exercises the upper-index cache when AWG_LOADER_UPPER_CACHE_EN is defined.
module tb_awg_seq_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [18:0] seq_index = '0;
    logic        busy, done, awg_sdata, awg_sclk, awg_load, mux_bit;
    logic [15:0] mux_data;
    logic [3:0]  mux_select;

    int checks = 0;
    int errors = 0;

    awg_seq_loader #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seq_index  (seq_index),
        .busy       (busy),
        .done       (done),
        .mux_data   (mux_data),
        .mux_select (mux_select),
        .mux_bit    (mux_bit),
        .awg_sdata  (awg_sdata),
        .awg_sclk   (awg_sclk),
        .awg_load   (awg_load)
    );

    always #5 clk = ~clk;

    // Downstream multiplexer: select k routes data[k+1].
    assign mux_bit = mux_data[mux_select + 4'd1];

    // AWG-side observer: bits sampled on sclk rising edges, strobe statistics.
    logic [63:0] bits = '0;
    int nbits = 0, loads = 0, load_cyc = 0, sclk_cyc = 0, overlap = 0;
    logic prev_sclk = 1'b0, prev_load = 1'b0;

    always @(negedge clk) begin
        if (awg_sclk === 1'b1 && prev_sclk === 1'b0) begin
            bits  <= {bits[62:0], awg_sdata};
            nbits <= nbits + 1;
        end
        if (awg_load === 1'b1 && prev_load === 1'b0) loads <= loads + 1;
        if (awg_load === 1'b1) load_cyc <= load_cyc + 1;
        if (awg_sclk === 1'b1) sclk_cyc <= sclk_cyc + 1;
        if (awg_sclk === 1'b1 && awg_load === 1'b1) overlap <= overlap + 1;
        prev_sclk <= awg_sclk;
        prev_load <= awg_load;
    end

    int s_nbits, s_loads, s_load_cyc, s_sclk_cyc;
    int lat;
    logic [15:0] md_first, md_mid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap;
        s_nbits    = nbits;
        s_loads    = loads;
        s_load_cyc = load_cyc;
        s_sclk_cyc = sclk_cyc;
    endtask

    // Present a start at the next negedge; returns right after the accepting edge.
    task automatic launch(input logic [18:0] v, input logic hold);
        @(negedge clk);
        snap();
        seq_index = v;
        start     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Count cycles after the accepting edge until done (bounded).
    task automatic wait_done(input int poke_at, input int rst_at, output int l);
        l = 999;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("busy_after_start", {63'd0, busy}, 64'd1);
                md_first = mux_data;
            end
            if (k == 70) md_mid = mux_data;
            if (poke_at > 0 && k == poke_at) start = 1'b1;
            if (poke_at > 0 && k == poke_at + 1) start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                l = k;
                return;
            end
            if (done === 1'b1) begin
                l = k;
                return;
            end
        end
    endtask

    task automatic check_xfer(input string tag, input int l, input int exp_lat,
                              input int exp_bits, input logic [63:0] exp_pat,
                              input int exp_loads);
        logic [63:0] mask;
        mask = (64'd1 << exp_bits) - 64'd1;
        check({tag, "_done_latency"}, 64'(l), 64'(exp_lat));
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_sclk_edges"}, 64'(nbits - s_nbits), 64'(exp_bits));
        check({tag, "_bit_pattern"}, bits & mask, exp_pat);
        check({tag, "_load_pulses"}, 64'(loads - s_loads), 64'(exp_loads));
        check({tag, "_load_cycles"}, 64'(load_cyc - s_load_cyc), 64'(exp_loads * 4));
        check({tag, "_sclk_high_cycles"}, 64'(sclk_cyc - s_sclk_cyc), 64'(exp_bits * 4));
    endtask

    localparam logic [63:0] PAT_5A5A5 = {43'd0, 7'b1101101, 14'b00010110100101};
    localparam logic [63:0] PAT_2A5A5 = {43'd0, 7'b1010101, 14'b00010110100101};

    initial begin
        // Reset held 3 cycles with start pulses that must be ignored.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start     = (i != 1);
            seq_index = 19'h5A5A5;
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sclk", {63'd0, awg_sclk}, 64'd0);
        check("rst_load", {63'd0, awg_load}, 64'd0);
        check("rst_sdata", {63'd0, awg_sdata}, 64'd0);
        check("rst_mux_data", {48'd0, mux_data}, 64'h0);
        check("rst_mux_select", {60'd0, mux_select}, 64'h0);
        @(negedge clk);
        check("idle_after_rst_busy", {63'd0, busy}, 64'd0);

        // Full transfer with an ignored start at t0+50.
        launch(19'h5A5A5, 1'b0);
        wait_done(50, 0, lat);
        check("full_mux_data_frame_a", {48'd0, md_first}, 64'h00B6);
        check("full_mux_data_frame_b", {48'd0, md_mid}, 64'h52D0);
        check_xfer("full", lat, 181, 21, PAT_5A5A5, 2);
        @(negedge clk);
        check("full_done_pulse_width", {63'd0, done}, 64'd0);
        check("full_idle_after", {63'd0, busy}, 64'd0);

        // Reset mid-transfer, then a clean full transfer.
        launch(19'h5A5A5, 1'b0);
        wait_done(0, 100, lat);
        @(negedge clk);
        check("midrst_sclk", {63'd0, awg_sclk}, 64'd0);
        check("midrst_load", {63'd0, awg_load}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        launch(19'h5A5A5, 1'b0);
        wait_done(0, 0, lat);
        check_xfer("after_rst", lat, 181, 21, PAT_5A5A5, 2);

        // Back-to-back with start held high; second index differs in its upper bits.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(19'h5A5A5, 1'b1);
        wait_done(0, 0, lat);
        check("b2b_first_latency", 64'(lat), 64'd181);
        check("b2b_busy_gap", {63'd0, busy}, 64'd0);
        snap();
        seq_index = 19'h2A5A5;
        wait_done(0, 0, lat);
        start = 1'b0;
        check_xfer("b2b_second", lat, 181, 21, PAT_2A5A5, 2);
        @(negedge clk);
        check("b2b_stopped_busy", {63'd0, busy}, 64'd0);
        check("b2b_stopped_done", {63'd0, done}, 64'd0);

`ifdef AWG_LOADER_UPPER_CACHE_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(19'h7E000, 1'b0);
        wait_done(0, 0, lat);
        check_xfer("cache_fill", lat, 181, 21, {43'd0, 7'b1111111, 14'd0}, 2);
        launch(19'h7E123, 1'b0);
        wait_done(0, 0, lat);
        check_xfer("cache_hit", lat, 117, 14, {50'd0, 14'b00000100100011}, 1);
        launch(19'h00123, 1'b0);
        wait_done(0, 0, lat);
        check_xfer("cache_miss", lat, 181, 21, {43'd0, 7'b1000000, 14'b00000100100011}, 2);
`endif

        @(negedge clk);
        check("sclk_load_overlap", 64'(overlap), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
